write_back_step: RTL and testbench

- Final pipeline stage, directly downstream of the memory step.
- Accepts retired instructions from the memory step over a valid/ready handshake.
- Aligns and sign/zero-extends load data, buffers results in a 2-entry FIFO, and drives the integer register-file write port, which may back-pressure via rf_ready_i.
- Flags misaligned loads and counts retired instructions.

---
 rtl/write_back_step.sv | 137 +++++++++++++
 tb/tb_write_back_step.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_step.sv
// Write-back stage: load alignment/extension, 2-entry result FIFO, register-file write port.
// Optional retired-instruction counter (instret_o) enabled by defining WB_RETIRE_COUNTER_EN.
module write_back_step #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic                  reg_write_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic [3:0]            mem_op_i,
    input  logic [1:0]            addr_lsb_i,
    input  logic [XLEN-1:0]       result_i,
    input  logic [XLEN-1:0]       load_data_i,
    input  logic                  rf_ready_i,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [XLEN-1:0]       rf_wdata_o,
    output logic                  misalign_o,
    output logic                  pending_o
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]           instret_o
`endif
);

    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic                  write;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t      fifo_q [DEPTH];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        misalign_q;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] sel_data;
    logic            misaligned;
    entry_t          new_entry;
    entry_t          head;
    logic            enq;
    logic            deq;

    // Load alignment and extension; unknown load widths behave as LW.
    always_comb begin
        misaligned = 1'b0;
        sel_data   = result_i;
        unique case (addr_lsb_i)
            2'd0:    byte_sel = load_data_i[7:0];
            2'd1:    byte_sel = load_data_i[15:8];
            2'd2:    byte_sel = load_data_i[23:16];
            default: byte_sel = load_data_i[31:24];
        endcase
        half_sel = addr_lsb_i[1] ? load_data_i[31:16] : load_data_i[15:0];
        if (mem_op_i[3]) begin
            unique case (mem_op_i[1:0])
                2'b00: begin
                    sel_data = mem_op_i[2] ? {{(XLEN-8){1'b0}}, byte_sel}
                                           : {{(XLEN-8){byte_sel[7]}}, byte_sel};
                end
                2'b01: begin
                    sel_data   = mem_op_i[2] ? {{(XLEN-16){1'b0}}, half_sel}
                                             : {{(XLEN-16){half_sel[15]}}, half_sel};
                    misaligned = addr_lsb_i[0];
                end
                default: begin
                    sel_data   = load_data_i;
                    misaligned = (addr_lsb_i != 2'b00);
                end
            endcase
        end
    end

    always_comb begin
        new_entry.write = reg_write_i && (rd_addr_i != '0) && !misaligned;
        new_entry.addr  = rd_addr_i;
        new_entry.data  = sel_data;
    end

    assign head        = fifo_q[rd_ptr_q];
    assign pending_o   = (count_q != 2'd0);
    assign mem_ready_o = (count_q != 2'(DEPTH)) && !rst_i;
    assign enq         = mem_valid_i && mem_ready_o;
    assign deq         = pending_o && (!head.write || rf_ready_i);

    assign rf_we_o    = pending_o && head.write;
    assign rf_waddr_o = pending_o ? head.addr : '0;
    assign rf_wdata_o = pending_o ? head.data : '0;
    assign misalign_o = misalign_q;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            misalign_q <= 1'b0;
        end else begin
            if (enq) begin
                fifo_q[wr_ptr_q] <= new_entry;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_q + 2'(enq) - 2'(deq);
            misalign_q <= enq && misaligned;
        end
    end

`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] instret_q;

    // Every dequeue retires, including x0 and misaligned entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instret_q <= 64'd0;
        end else if (deq) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_write_back_step.sv
// Bench for write_back_step: directed scenarios then random traffic against a queue-based model.
// Covers instret_o as well when WB_RETIRE_COUNTER_EN is defined.
module tb_write_back_step;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic        reg_write_i;
    logic [4:0]  rd_addr_i;
    logic [3:0]  mem_op_i;
    logic [1:0]  addr_lsb_i;
    logic [31:0] result_i;
    logic [31:0] load_data_i;
    logic        rf_ready_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        misalign_o;
    logic        pending_o;
`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] instret_o;
`endif

    write_back_step dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .reg_write_i (reg_write_i),
        .rd_addr_i   (rd_addr_i),
        .mem_op_i    (mem_op_i),
        .addr_lsb_i  (addr_lsb_i),
        .result_i    (result_i),
        .load_data_i (load_data_i),
        .rf_ready_i  (rf_ready_i),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .misalign_o  (misalign_o),
        .pending_o   (pending_o)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .instret_o   (instret_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          exp_mis;
    logic [63:0] exp_instret;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(logic [3:0] op, logic [1:0] lsb,
                                             logic [31:0] res, logic [31:0] ld);
        int unsigned f = op[2:0];
        logic [31:0] v;
        if (!op[3]) return res;
        if (f == 0 || f == 4) begin
            v = (ld >> (8 * lsb)) & 32'hFF;
            if (f == 0 && v >= 128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (f == 1 || f == 5) begin
            v = (ld >> (16 * (lsb / 2))) & 32'hFFFF;
            if (f == 1 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return ld;
    endfunction

    function automatic bit exp_misaligned(logic [3:0] op, logic [1:0] lsb);
        int unsigned f = op[2:0];
        if (!op[3]) return 1'b0;
        if (f == 0 || f == 4) return 1'b0;
        if (f == 1 || f == 5) return lsb[0];
        return lsb != 2'b00;
    endfunction

    // Compare every output with the model, then advance one clock and update the model.
    task automatic cycle(output bit acc);
        bit   enq;
        bit   deq;
        bit   head_we;
        ent_t e;
        #3;
        head_we = (q.size() != 0) && q[0].we;
        chk("mem_ready", 64'(mem_ready_o), 64'((q.size() < 2) && !rst_i));
        chk("pending", 64'(pending_o), 64'(q.size() != 0));
        chk("rf_we", 64'(rf_we_o), 64'(head_we));
        chk("misalign", 64'(misalign_o), 64'(exp_mis));
        if (head_we) begin
            chk("rf_waddr", 64'(rf_waddr_o), 64'(q[0].addr));
            chk("rf_wdata", 64'(rf_wdata_o), 64'(q[0].data));
        end else if (q.size() == 0) begin
            chk("rf_waddr_idle", 64'(rf_waddr_o), 64'd0);
            chk("rf_wdata_idle", 64'(rf_wdata_o), 64'd0);
        end
`ifdef WB_RETIRE_COUNTER_EN
        chk("instret", instret_o, exp_instret);
`endif
        enq = mem_valid_i && (q.size() < 2) && !rst_i;
        deq = (q.size() != 0) && (!q[0].we || rf_ready_i);
        e.we   = reg_write_i && (rd_addr_i != 0) && !exp_misaligned(mem_op_i, addr_lsb_i);
        e.addr = rd_addr_i;
        e.data = exp_data(mem_op_i, addr_lsb_i, result_i, load_data_i);
        @(posedge clk_i);
        #1;
        if (deq) begin
            void'(q.pop_front());
            exp_instret = exp_instret + 64'd1;
        end
        if (enq) q.push_back(e);
        exp_mis = enq && exp_misaligned(mem_op_i, addr_lsb_i);
        acc = enq;
    endtask

    task automatic drive(input bit v, input bit rw, input logic [4:0] rd, input logic [3:0] op,
                         input logic [1:0] lsb, input logic [31:0] res, input logic [31:0] ld);
        mem_valid_i = v;
        reg_write_i = rw;
        rd_addr_i   = rd;
        mem_op_i    = op;
        addr_lsb_i  = lsb;
        result_i    = res;
        load_data_i = ld;
    endtask

    task automatic model_reset();
        q.delete();
        exp_mis     = 1'b0;
        exp_instret = 64'd0;
    endtask

    initial begin
        bit          acc;
        int          budget;
        logic [31:0] val;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_i      = 1'b1;
        rf_ready_i = 1'b1;
        drive(0, 0, 5'd0, 4'd0, 2'd0, 32'd0, 32'd0);
        #1;
        chk("reset_ready", 64'(mem_ready_o), 64'd0);
        chk("reset_we", 64'(rf_we_o), 64'd0);
        chk("reset_pending", 64'(pending_o), 64'd0);
        chk("reset_misalign", 64'(misalign_o), 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle(acc);

        // LB and LBU of byte 3
        drive(1, 1, 5'd5, 4'b1000, 2'd3, 32'd0, 32'h80FF_1234);
        cycle(acc);
        chk("lb_we", 64'(rf_we_o), 64'd1);
        chk("lb_addr", 64'(rf_waddr_o), 64'd5);
        chk("lb_data", 64'(rf_wdata_o), 64'hFFFF_FF80);
        drive(1, 1, 5'd5, 4'b1100, 2'd3, 32'd0, 32'h80FF_1234);
        cycle(acc);
        chk("lbu_data", 64'(rf_wdata_o), 64'h0000_0080);
        drive(0, 0, 5'd0, 4'd0, 2'd0, 32'd0, 32'd0);
        cycle(acc);

        // Misaligned LH
        drive(1, 1, 5'd7, 4'b1001, 2'd1, 32'd0, 32'h1234_5678);
        cycle(acc);
        drive(0, 0, 5'd0, 4'd0, 2'd0, 32'd0, 32'd0);
        chk("lh_mis_pulse", 64'(misalign_o), 64'd1);
        chk("lh_mis_we", 64'(rf_we_o), 64'd0);
        chk("lh_mis_ready", 64'(mem_ready_o), 64'd1);
        cycle(acc);
        chk("lh_mis_clear", 64'(misalign_o), 64'd0);
        cycle(acc);

        // Back-pressure: three ALU results with register file stalled
        rf_ready_i = 1'b0;
        drive(1, 1, 5'd1, 4'd0, 2'd0, 32'h11, 32'd0);
        cycle(acc);
        drive(1, 1, 5'd2, 4'd0, 2'd0, 32'h22, 32'd0);
        cycle(acc);
        drive(1, 1, 5'd3, 4'd0, 2'd0, 32'h33, 32'd0);
        #1;
        chk("full_ready", 64'(mem_ready_o), 64'd0);
        cycle(acc);
        rf_ready_i = 1'b1;
        chk("drain_x1", 64'(rf_wdata_o), 64'h11);
        budget = 10;
        acc = 1'b0;
        while (!acc && budget > 0) begin
            cycle(acc);
            budget--;
        end
        chk("x3_accept_in_time", 64'(acc), 64'd1);
        drive(0, 0, 5'd0, 4'd0, 2'd0, 32'd0, 32'd0);
        chk("drain_x3_addr", 64'(rf_waddr_o), 64'd3);
        chk("drain_x3_data", 64'(rf_wdata_o), 64'h33);
        cycle(acc);
        cycle(acc);

        // Write to x0 never reaches the port, dequeues without rf_ready
        rf_ready_i = 1'b0;
        drive(1, 1, 5'd0, 4'd0, 2'd0, 32'hDEAD, 32'd0);
        cycle(acc);
        drive(0, 0, 5'd0, 4'd0, 2'd0, 32'd0, 32'd0);
        chk("x0_pending", 64'(pending_o), 64'd1);
        chk("x0_we", 64'(rf_we_o), 64'd0);
        cycle(acc);
        chk("x0_gone", 64'(pending_o), 64'd0);

        // Reset with a full FIFO
        drive(1, 1, 5'd9, 4'd0, 2'd0, 32'hAAAA, 32'd0);
        cycle(acc);
        drive(1, 1, 5'd10, 4'd0, 2'd0, 32'hBBBB, 32'd0);
        cycle(acc);
        drive(0, 0, 5'd0, 4'd0, 2'd0, 32'd0, 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        model_reset();
        chk("midrst_we", 64'(rf_we_o), 64'd0);
        chk("midrst_waddr", 64'(rf_waddr_o), 64'd0);
        chk("midrst_wdata", 64'(rf_wdata_o), 64'd0);
        chk("midrst_pending", 64'(pending_o), 64'd0);
        chk("midrst_ready", 64'(mem_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        rf_ready_i = 1'b1;
        cycle(acc);
        chk("postrst_pending", 64'(pending_o), 64'd0);
        chk("postrst_we", 64'(rf_we_o), 64'd0);

        // Steady stream: one write per cycle, ready never drops
        for (int i = 0; i < 10; i++) begin
            val = 32'h100 + 32'(i);
            drive(1, 1, 5'(i + 1), 4'd0, 2'd0, val, 32'd0);
            cycle(acc);
            chk("stream_ready", 64'(mem_ready_o), 64'd1);
            chk("stream_data", 64'(rf_wdata_o), 64'(val));
        end
        drive(0, 0, 5'd0, 4'd0, 2'd0, 32'd0, 32'd0);
        cycle(acc);
        cycle(acc);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rf_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                mem_op_i = 4'($urandom_range(0, 7));
            else
                mem_op_i = {1'b1, 3'($urandom_range(0, 7))};
            mem_valid_i = 1'($urandom_range(0, 1));
            reg_write_i = ($urandom_range(0, 7) != 0);
            rd_addr_i   = 5'($urandom_range(0, 31));
            addr_lsb_i  = 2'($urandom_range(0, 3));
            result_i    = $urandom;
            load_data_i = $urandom;
            cycle(acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
